// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared encodings for the SPI memory access path (FSM states, access sizes, bus owners).
package rv_mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/spi_mem_arbiter_load_extend.sv
// load_extend: selects byte/half/word from a little-endian fetched word and sign- or zero-extends it.
module load_extend
   import rv_mem_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   output logic [31:0] result
);

   always_comb
      result = size == SZ_BYTE ? {{24{~zero_ext & raw[7]}}, raw[7:0]} :
               size == SZ_HALF ? {{16{~zero_ext & raw[15]}}, raw[15:0]} :
               raw;

endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI read engine between instruction fetch and load unit,
// with tie arbitration, start/done sequencing, a BUSY watchdog and load data extension.
module spi_mem_arbiter
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter bit PRIO_LS = 1'b1,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [1:0]        ls_size,
   input  logic              ls_unsigned,
   output logic              ls_valid,
   output logic [31:0]       ls_rdata,
   output logic              err,
   output logic              mem_start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_done,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state, state_d;
   owner_t            owner, owner_d, last_owner, last_owner_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              mem_start_d, if_valid_d, ls_valid_d, err_d, busy_d, timeout, pick_ls;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [31:0]       if_rdata_d, ls_rdata_d, ext_data;

   load_extend u_ext (
      .raw      (mem_rdata),
      .size     (size_q),
      .zero_ext (uns_q),
      .result   (ext_data)
   );

   // On a tie, round-robin hands the bus to whichever requester was not served last.
   always_comb
      pick_ls = if_req && ls_req ? (PRIO_LS || last_owner == OWN_IF) : ls_req;

   always_comb begin
      state_d      = state;
      owner_d      = owner;
      last_owner_d = last_owner;
      size_d       = size_q;
      uns_d        = uns_q;
      cnt_d        = cnt;
      mem_addr_d   = mem_addr;
      mem_start_d  = 1'b0;
      if_valid_d   = 1'b0;
      ls_valid_d   = 1'b0;
      err_d        = 1'b0;
      if_rdata_d   = if_rdata;
      ls_rdata_d   = ls_rdata;
      timeout      = 1'b0;
      case (state)
         IDLE:
            if (if_req || ls_req) begin
               owner_d     = pick_ls ? OWN_LS : OWN_IF;
               mem_addr_d  = pick_ls ? ls_addr : if_addr;
               size_d      = ls_size;
               uns_d       = ls_unsigned;
               cnt_d       = '0;
               mem_start_d = 1'b1;
               state_d     = BUSY;
            end
         BUSY: begin
            cnt_d   = cnt + 1'b1;
            timeout = !mem_done && cnt_d == CNT_W'(TIMEOUT);
            if (mem_done || timeout) begin
               state_d    = RESP;
               err_d      = timeout;
               if_valid_d = owner == OWN_IF;
               ls_valid_d = owner == OWN_LS;
               if_rdata_d = owner == OWN_IF ? (timeout ? 32'd0 : mem_rdata) : if_rdata;
               ls_rdata_d = owner == OWN_LS ? (timeout ? 32'd0 : ext_data) : ls_rdata;
            end else
               mem_start_d = 1'b1;
         end
         RESP: begin
            last_owner_d = owner;
            state_d      = DRAIN;
         end
         DRAIN:
            if (!mem_done)
               state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         last_owner <= OWN_IF;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         cnt        <= '0;
         mem_addr   <= '0;
         mem_start  <= 1'b0;
         if_valid   <= 1'b0;
         ls_valid   <= 1'b0;
         err        <= 1'b0;
         if_rdata   <= '0;
         ls_rdata   <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         last_owner <= last_owner_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         cnt        <= cnt_d;
         mem_addr   <= mem_addr_d;
         mem_start  <= mem_start_d;
         if_valid   <= if_valid_d;
         ls_valid   <= ls_valid_d;
         err        <= err_d;
         if_rdata   <= if_rdata_d;
         ls_rdata   <= ls_rdata_d;
         busy       <= busy_d;
      end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: scoreboard bench for spi_mem_arbiter; instance a uses LS priority,
// instance b uses round-robin with a short watchdog, and sel picks which one the bench observes.
module tb_spi_mem_arbiter;
   import rv_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, ls_req = 1'b0, ls_unsigned = 1'b0;
   logic [23:0] if_addr = '0, ls_addr = '0;
   logic [1:0]  ls_size = 2'b00;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = '0, mem_rdata;
   logic        sel = 1'b0, never = 1'b0, hold_done = 1'b0;
   int          mem_delay = 5;
   int          passed = 0, total = 0;

   logic        a_if_valid, a_ls_valid, a_err, a_mem_start, a_busy;
   logic [31:0] a_if_rdata, a_ls_rdata;
   logic [23:0] a_mem_addr;
   logic        b_if_valid, b_ls_valid, b_err, b_mem_start, b_busy;
   logic [31:0] b_if_rdata, b_ls_rdata;
   logic [23:0] b_mem_addr;
   logic        o_if_valid, o_ls_valid, o_err, o_mem_start, o_busy;
   logic [31:0] o_if_rdata, o_ls_rdata;
   logic [23:0] o_mem_addr;

   typedef struct packed {logic own; logic [31:0] data; logic err;} exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   assign mem_rdata = mem_data;

   assign o_if_valid  = sel ? b_if_valid  : a_if_valid;
   assign o_ls_valid  = sel ? b_ls_valid  : a_ls_valid;
   assign o_err       = sel ? b_err       : a_err;
   assign o_mem_start = sel ? b_mem_start : a_mem_start;
   assign o_busy      = sel ? b_busy      : a_busy;
   assign o_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
   assign o_ls_rdata  = sel ? b_ls_rdata  : a_ls_rdata;
   assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;

   spi_mem_arbiter #(.ADDR_W(24), .PRIO_LS(1'b1), .TIMEOUT(1023)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(a_if_valid), .if_rdata(a_if_rdata),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
      .ls_valid(a_ls_valid), .ls_rdata(a_ls_rdata), .err(a_err),
      .mem_start(a_mem_start), .mem_addr(a_mem_addr), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .busy(a_busy)
   );

   spi_mem_arbiter #(.ADDR_W(24), .PRIO_LS(1'b0), .TIMEOUT(15)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
      .ls_valid(b_ls_valid), .ls_rdata(b_ls_rdata), .err(b_err),
      .mem_start(b_mem_start), .mem_addr(b_mem_addr), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .busy(b_busy)
   );

   // mem_read model: done rises mem_delay cycles into a fetch and stays up until start drops
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         if (hold_done)
            mem_done = 1'b1;
         else if (!o_mem_start) begin
            c = 0;
            mem_done = 1'b0;
         end else if (!mem_done) begin
            c++;
            if (!never && c >= mem_delay)
               mem_done = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      if_req = 1'b0;
      ls_req = 1'b0;
      never = 1'b0;
      hold_done = 1'b0;
      q.delete();
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic get_resp(output logic ok, output logic own, output logic [31:0] data,
                           output logic err, output logic both);
      ok = 1'b0; own = 1'b0; data = '0; err = 1'b0; both = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (o_if_valid || o_ls_valid) begin
            ok   = 1'b1;
            own  = o_ls_valid;
            data = o_ls_valid ? o_ls_rdata : o_if_rdata;
            err  = o_err;
            both = o_if_valid && o_ls_valid;
         end
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      cyc(1);
      total++; if (o_mem_start !== 1'b0) $display("FAIL reset_start: got %b want 0", o_mem_start); else passed++;
      total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passed++;
      total++; if ({o_if_valid, o_ls_valid, o_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {o_if_valid, o_ls_valid, o_err}); else passed++;
      total++; if ({o_if_rdata, o_ls_rdata, o_mem_addr} !== 88'd0) $display("FAIL reset_data: got %h want 0", {o_if_rdata, o_ls_rdata, o_mem_addr}); else passed++;
   endtask

   task automatic test_if_only();
      logic ok, own, err, both;
      logic [31:0] data;
      exp_t e;
      mem_delay = 70;
      mem_data = 32'h00500093;
      if_addr = 24'h000010;
      if_req = 1'b1;
      q.push_back('{OWN_IF, 32'h00500093, 1'b0});
      cyc(1);
      total++; if (o_mem_start !== 1'b1) $display("FAIL if_start_latency: got %b want 1", o_mem_start); else passed++;
      total++; if (o_mem_addr !== 24'h000010) $display("FAIL if_mem_addr: got %h want 000010", o_mem_addr); else passed++;
      get_resp(ok, own, data, err, both);
      if_req = 1'b0;
      e = q.pop_front();
      total++; if (ok !== 1'b1) $display("FAIL if_resp_seen: got %b want 1", ok); else passed++;
      total++; if (own !== e.own || both !== 1'b0) $display("FAIL if_owner: got own=%b both=%b want own=%b both=0", own, both, e.own); else passed++;
      total++; if (data !== e.data) $display("FAIL if_rdata: got %h want %h", data, e.data); else passed++;
      total++; if (err !== e.err) $display("FAIL if_err: got %b want %b", err, e.err); else passed++;
      cyc(1);
      total++; if (o_if_valid !== 1'b0) $display("FAIL if_valid_pulse: got %b want 0", o_if_valid); else passed++;
      cyc(2);
   endtask

   task automatic test_tie_prio();
      logic ok, own, err, both;
      logic [31:0] data;
      exp_t e;
      do_reset();
      mem_delay = 4;
      mem_data = 32'hCAFEBABE;
      ls_addr = 24'h000100;
      ls_size = 2'b10;
      if_addr = 24'h000040;
      if_req = 1'b1;
      ls_req = 1'b1;
      q.push_back('{OWN_LS, 32'hCAFEBABE, 1'b0});
      q.push_back('{OWN_IF, 32'hCAFEBABE, 1'b0});
      for (int k = 0; k < 2; k++) begin
         get_resp(ok, own, data, err, both);
         if (own) ls_req = 1'b0; else if_req = 1'b0;
         e = q.pop_front();
         total++; if (ok !== 1'b1 || own !== e.own || both !== 1'b0) $display("FAIL prio_owner_%0d: got ok=%b own=%b both=%b want own=%b", k, ok, own, both, e.own); else passed++;
         total++; if (data !== e.data || err !== e.err) $display("FAIL prio_data_%0d: got %h/%b want %h/%b", k, data, err, e.data, e.err); else passed++;
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      cyc(3);
   endtask

   task automatic test_round_robin();
      logic ok, own, err, both;
      logic [31:0] data;
      exp_t e;
      sel = 1'b1;
      do_reset();
      mem_delay = 3;
      mem_data = 32'h11223344;
      ls_size = 2'b10;
      ls_req = 1'b1;
      q.push_back('{OWN_LS, 32'h11223344, 1'b0});
      get_resp(ok, own, data, err, both);
      ls_req = 1'b0;
      e = q.pop_front();
      total++; if (ok !== 1'b1 || own !== e.own) $display("FAIL rr_prime: got ok=%b own=%b want own=%b", ok, own, e.own); else passed++;
      cyc(3);
      if_req = 1'b1;
      ls_req = 1'b1;
      q.push_back('{OWN_IF, 32'h11223344, 1'b0});
      q.push_back('{OWN_LS, 32'h11223344, 1'b0});
      q.push_back('{OWN_IF, 32'h11223344, 1'b0});
      q.push_back('{OWN_LS, 32'h11223344, 1'b0});
      for (int k = 0; k < 4; k++) begin
         get_resp(ok, own, data, err, both);
         e = q.pop_front();
         total++; if (ok !== 1'b1 || own !== e.own || both !== 1'b0 || data !== e.data) $display("FAIL rr_owner_%0d: got ok=%b own=%b both=%b data=%h want own=%b data=%h", k, ok, own, both, data, e.own, e.data); else passed++;
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      cyc(3);
   endtask

   task automatic test_load_extend();
      logic ok, own, err, both;
      logic [31:0] data;
      exp_t e;
      logic [1:0]  sz_tab [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      logic        un_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ex_tab [6] = '{32'hFFFFFF8A, 32'h0000008A, 32'hFFFFF08A, 32'h0000F08A, 32'h1234F08A, 32'h1234F08A};
      sel = 1'b0;
      do_reset();
      mem_delay = 2;
      mem_data = 32'h1234F08A;
      for (int k = 0; k < 6; k++) begin
         ls_size = sz_tab[k];
         ls_unsigned = un_tab[k];
         ls_addr = 24'h000200 + 24'(k);
         ls_req = 1'b1;
         q.push_back('{OWN_LS, ex_tab[k], 1'b0});
         get_resp(ok, own, data, err, both);
         ls_req = 1'b0;
         e = q.pop_front();
         total++; if (ok !== 1'b1 || own !== e.own || data !== e.data || err !== e.err) $display("FAIL ext_%0d: got ok=%b own=%b data=%h err=%b want own=%b data=%h err=%b", k, ok, own, data, err, e.own, e.data, e.err); else passed++;
      end
      ls_unsigned = 1'b0;
      cyc(3);
   endtask

   task automatic test_timeout();
      logic ok, own, err, both;
      logic [31:0] data;
      logic fin;
      int n;
      exp_t e;
      sel = 1'b1;
      never = 1'b1;
      if_addr = 24'h000020;
      if_req = 1'b1;
      q.push_back('{OWN_IF, 32'd0, 1'b1});
      n = 0;
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         @(negedge clk);
         if (o_mem_start) n++;
         else if (n > 0) fin = 1'b1;
      end
      e = q.pop_front();
      total++; if (n != 15) $display("FAIL to_busy_cycles: got %0d want 15", n); else passed++;
      total++; if (o_if_valid !== 1'b1 || o_err !== e.err) $display("FAIL to_valid_err: got valid=%b err=%b want 1/%b", o_if_valid, o_err, e.err); else passed++;
      total++; if (o_if_rdata !== e.data) $display("FAIL to_rdata: got %h want %h", o_if_rdata, e.data); else passed++;
      if_req = 1'b0;
      never = 1'b0;
      mem_delay = 3;
      mem_data = 32'hA5A50F0F;
      ls_size = 2'b10;
      ls_req = 1'b1;
      q.push_back('{OWN_LS, 32'hA5A50F0F, 1'b0});
      get_resp(ok, own, data, err, both);
      ls_req = 1'b0;
      e = q.pop_front();
      total++; if (ok !== 1'b1 || own !== e.own || data !== e.data || err !== e.err) $display("FAIL to_recover: got ok=%b own=%b data=%h err=%b want own=%b data=%h err=%b", ok, own, data, err, e.own, e.data, e.err); else passed++;
      cyc(3);
   endtask

   task automatic test_reset_mid();
      logic ok, own, err, both;
      logic [31:0] data;
      logic quiet;
      exp_t e;
      sel = 1'b0;
      do_reset();
      mem_delay = 40;
      if_addr = 24'h000080;
      if_req = 1'b1;
      cyc(6);
      total++; if (o_busy !== 1'b1 || o_mem_start !== 1'b1) $display("FAIL rst_pre_busy: got busy=%b start=%b want 1/1", o_busy, o_mem_start); else passed++;
      rst_n = 1'b0;
      if_req = 1'b0;
      hold_done = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      total++; if ({o_mem_start, o_busy, o_if_valid, o_ls_valid} !== 4'b0000) $display("FAIL rst_mid: got start/busy/ifv/lsv=%b want 0000", {o_mem_start, o_busy, o_if_valid, o_ls_valid}); else passed++;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (o_busy || o_mem_start || o_if_valid || o_ls_valid) quiet = 1'b0;
      end
      total++; if (quiet !== 1'b1) $display("FAIL rst_stale_done: got activity=%b want none", ~quiet); else passed++;
      hold_done = 1'b0;
      cyc(2);
      mem_delay = 5;
      mem_data = 32'h0BADF00D;
      if_req = 1'b1;
      q.push_back('{OWN_IF, 32'h0BADF00D, 1'b0});
      get_resp(ok, own, data, err, both);
      if_req = 1'b0;
      e = q.pop_front();
      total++; if (ok !== 1'b1 || own !== e.own || data !== e.data || err !== e.err) $display("FAIL rst_recover: got ok=%b own=%b data=%h err=%b want own=%b data=%h err=%b", ok, own, data, err, e.own, e.data, e.err); else passed++;
      cyc(3);
   endtask

   initial begin
      test_reset();
      test_if_only();
      test_tie_prio();
      test_round_robin();
      test_load_extend();
      test_timeout();
      test_reset_mid();
      total++; if (q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", q.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
